if_stage: RTL and testbench

Instruction fetch stage with integrated IF/ID pipeline register for the RV32I in-order pipeline. It holds the PC and fetches from instruction memory over a single-outstanding request/response handshake. It presents `instruction` plus its PC to the decode stage (`cu`, immediate generator, register file). It honours hazard-unit stalls and resolved branch/jump redirects, discarding wrong-path fetches.

---
 rtl/rv32i_defs.sv | 31 +++
 rtl/if_stage.sv | 178 +++++++++++++++++
 tb/tb_if_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_defs.sv
// ----------------------------------------------------------------------------
// rv32i_defs
// Shared definitions for the RV32I in-order pipeline.
//   PC_WIDTH        width of every program counter in the pipeline
//   INST_WIDTH      width of an instruction word
//   RV32I_NOP_INST  canonical NOP (addi x0,x0,0) used for pipeline bubbles
//   IF_STATE_WIDTH  width of the fetch-stage FSM encoding
//   if_state_e      fetch-stage FSM states
//   align_pc()      clears the byte-offset bits of a PC
// ----------------------------------------------------------------------------
package rv32i_defs;

    localparam int PC_WIDTH   = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] RV32I_NOP_INST = 32'h0000_0013;

    localparam int IF_STATE_WIDTH = 2;

    typedef enum logic [IF_STATE_WIDTH-1:0] {
        IF_FETCH = 2'd0,  // ready to issue a request at pc_q
        IF_WAIT  = 2'd1,  // one request outstanding, waiting for its response
        IF_HOLD  = 2'd2   // response parked in the skid buffer during a stall
    } if_state_e;

    // Instructions are word aligned; the low two bits never reach memory.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage plus IF/ID pipeline register. Keeps the fetch PC,
// issues one instruction-memory request at a time, and hands the returned
// word (with its PC) to decode. Stalls park a late response in a one-entry
// skid buffer; redirects flush IF/ID and discard any wrong-path response.
//
// Parameters
//   RESET_PC       first PC fetched after reset
//   INST_WIDTH     instruction word width
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   imem_req       fetch request valid (combinational from state/pc/redirect)
//   imem_addr      word-aligned fetch address
//   imem_ready     memory accepts the request this cycle
//   imem_rvalid    response valid, one per accepted request
//   imem_rdata     fetched instruction
//   stall          hazard unit: hold IF/ID
//   redirect       resolved branch/jump redirect
//   redirect_pc    redirect target (low two bits ignored)
//   ifid_valid     IF/ID holds a real instruction
//   ifid_instr     instruction for decode, NOP when not valid
//   ifid_pc        PC of ifid_instr
//   ifid_pc_plus4  ifid_pc + 4 for JAL/JALR link value
// ----------------------------------------------------------------------------
module if_stage
    import rv32i_defs::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                  INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,

    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,

    output logic                  ifid_valid,
    output logic [INST_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]   ifid_pc,
    output logic [PC_WIDTH-1:0]   ifid_pc_plus4
);

    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(RV32I_NOP_INST);

    if_state_e              state_q,      state_d;
    logic [PC_WIDTH-1:0]    pc_q,         pc_d;
    logic [PC_WIDTH-1:0]    req_pc_q,     req_pc_d;
    logic [INST_WIDTH-1:0]  buf_instr_q,  buf_instr_d;
    logic [PC_WIDTH-1:0]    buf_pc_q,     buf_pc_d;
    logic                   kill_q,       kill_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic [INST_WIDTH-1:0]  ifid_instr_q, ifid_instr_d;
    logic [PC_WIDTH-1:0]    ifid_pc_q,    ifid_pc_d;

    // The byte-offset bits of the target are dropped by align_pc().
    logic redirect_pc_unused;
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Requests depend only on state, PC and redirect so the memory side never
    // sees a path from its own response back into the request.
    assign imem_req  = (state_q == IF_FETCH) && !redirect;
    assign imem_addr = pc_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        kill_d      = kill_q;

        // Without a load, IF/ID holds under stall and otherwise drains to a
        // bubble. The PC field is left alone; it is meaningless when invalid.
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (!stall) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
        end

        if (redirect) begin
            // Redirect overrides stall and any load in the same cycle.
            pc_d         = align_pc(redirect_pc);
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
            if (state_q == IF_WAIT && !imem_rvalid) begin
                // The in-flight response still has to arrive; mark it stale.
                kill_d = 1'b1;
            end else begin
                // Response (if any) is dropped now; skid contents are abandoned.
                kill_d  = 1'b0;
                state_d = IF_FETCH;
            end
        end else begin
            unique case (state_q)
                IF_FETCH: begin
                    if (imem_ready) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_WIDTH'(4);
                        state_d  = IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = IF_FETCH;
                        end else if (!stall) begin
                            ifid_valid_d = 1'b1;
                            ifid_instr_d = imem_rdata;
                            ifid_pc_d    = req_pc_q;
                            state_d      = IF_FETCH;
                        end else begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = req_pc_q;
                            state_d     = IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (!stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = buf_instr_q;
                        ifid_pc_d    = buf_pc_q;
                        state_d      = IF_FETCH;
                    end
                end
                default: begin
                    state_d = IF_FETCH;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IF_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            buf_instr_q  <= NOP;
            buf_pc_q     <= '0;
            kill_q       <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            kill_q       <= kill_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    assign ifid_valid    = ifid_valid_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_q + PC_WIDTH'(4);

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Directed vector table for the fetch-stage corner cases, a reset-in-WAIT
// sequence, then a randomized run against a stream-level reference: delivered
// instructions must follow the program-order PC stream (restarting at each
// redirect target), carry the memory word at their PC, hold under stall, and
// turn into bubbles after redirects.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;

    int total = 0;
    int bad   = 0;

    if_stage #(.RESET_PC(RST_PC), .INST_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image used by the random phase.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stl;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic st, input logic rdr, input logic [31:0] rp,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.stl = st; v.redir = rdr; v.rpc = rp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    localparam int NV = 25;
    vec_t vecs [NV];

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h00A0_0113;
    localparam logic [31:0] I2 = 32'h0010_0193;
    localparam logic [31:0] IT = 32'h0640_0213;
    localparam logic [31:0] IW = 32'h0000_0033;

    // Random-phase reference state.
    logic        pend, acc, prev_stall, prev_redir;
    logic        prev_valid;
    logic [31:0] prev_instr, prev_pc;
    logic [31:0] raddr, acc_addr, exp_pc;
    int          cnt;
    int          deliveries;

    initial begin
        //                 rdy rv rdata         st rd rpc            req addr          v  instr pc
        vecs[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h100,      0, NOP, 32'h0);
        vecs[1]  = mk(1, 1, I0,           0, 0, 32'h0,         0, 32'h104,      0, NOP, 32'h0);
        vecs[2]  = mk(1, 0, 32'h0,        1, 0, 32'h0,         1, 32'h104,      1, I0,  32'h100);
        vecs[3]  = mk(1, 1, I1,           1, 0, 32'h0,         0, 32'h108,      1, I0,  32'h100);
        vecs[4]  = mk(1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h108,      1, I0,  32'h100);
        vecs[5]  = mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h108,      1, I0,  32'h100);
        vecs[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h108,      1, I1,  32'h104);
        vecs[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h108,      0, NOP, 32'h0);
        vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h108,      0, NOP, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h108,      0, NOP, 32'h0);
        vecs[10] = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h108,      0, NOP, 32'h0);
        vecs[11] = mk(1, 0, 32'h0,        0, 1, 32'h200,       0, 32'h10C,      0, NOP, 32'h0);
        vecs[12] = mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h200,      0, NOP, 32'h0);
        vecs[13] = mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h200,      0, NOP, 32'h0);
        vecs[14] = mk(1, 1, I2,           0, 0, 32'h0,         0, 32'h200,      0, NOP, 32'h0);
        vecs[15] = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h200,      0, NOP, 32'h0);
        vecs[16] = mk(1, 1, IT,           0, 0, 32'h0,         0, 32'h204,      0, NOP, 32'h0);
        vecs[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h204,      1, IT,  32'h200);
        vecs[18] = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h204,      0, NOP, 32'h0);
        vecs[19] = mk(1, 1, 32'hDEADBEEF, 0, 1, 32'h203,       0, 32'h208,      0, NOP, 32'h0);
        vecs[20] = mk(1, 0, 32'h0,        0, 1, 32'hFFFF_FFFC, 0, 32'h200,      0, NOP, 32'h0);
        vecs[21] = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFF_FFFC,0, NOP, 32'h0);
        vecs[22] = mk(1, 1, IW,           0, 0, 32'h0,         0, 32'h0,        0, NOP, 32'h0);
        vecs[23] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        1, IW,  32'hFFFF_FFFC);
        vecs[24] = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, NOP, 32'h0);

        rst = 1'b1;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset values, with memory claiming to be ready: nothing may be accepted.
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req",    {31'b0, imem_req}, 32'd1);
        check("rst_addr",   imem_addr, RST_PC);
        check("rst_valid",  {31'b0, ifid_valid}, 32'd0);
        check("rst_instr",  ifid_instr, NOP);
        check("rst_pc",     ifid_pc, 32'h0);
        check("rst_pc4",    ifid_pc_plus4, 32'h4);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            imem_ready  = vecs[i].ready;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            stall       = vecs[i].stl;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
            check($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_instr", i), ifid_instr, vecs[i].e_instr);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc", i),  ifid_pc, vecs[i].e_pc);
                check($sformatf("v%0d_pc4", i), ifid_pc_plus4, vecs[i].e_pc + 32'd4);
            end
            @(posedge clk); #1;
        end

        // Last vector was accepted, so the stage is now WAITing on 0x0.
        imem_ready = 1'b0; imem_rvalid = 1'b0; stall = 1'b1; redirect = 1'b0;
        @(negedge clk);
        check("wait_no_req", {31'b0, imem_req}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_req",   {31'b0, imem_req}, 32'd1);
        check("midrst_addr",  imem_addr, RST_PC);
        check("midrst_valid", {31'b0, ifid_valid}, 32'd0);
        check("midrst_instr", ifid_instr, NOP);
        check("midrst_pc4",   ifid_pc_plus4, 32'h4);

        // ---------------- randomized phase ----------------
        stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pend = 1'b0; acc = 1'b0; cnt = 0; raddr = '0; acc_addr = '0;
        prev_stall = 1'b0; prev_redir = 1'b0;
        prev_valid = 1'b0; prev_instr = NOP; prev_pc = '0;
        exp_pc = RST_PC; deliveries = 0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (acc) begin
                pend  = 1'b1;
                cnt   = int'($urandom_range(1, 3));
                raddr = acc_addr;
            end
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) begin
                if (cnt == 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(raddr);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            imem_ready  = ($urandom_range(0, 9) < 7);

            @(negedge clk);
            check("r_addr_align",  {30'b0, imem_addr[1:0]}, 32'd0);
            check("r_req_masked",  {31'b0, imem_req & redirect}, 32'd0);
            check("r_single_outst", {31'b0, imem_req & (pend | imem_rvalid)}, 32'd0);
            if (!ifid_valid)
                check("r_bubble_nop", ifid_instr, NOP);

            if (prev_redir) begin
                check("r_flush_valid", {31'b0, ifid_valid}, 32'd0);
            end else if (prev_stall) begin
                check("r_hold_valid", {31'b0, ifid_valid}, {31'b0, prev_valid});
                check("r_hold_instr", ifid_instr, prev_instr);
                if (prev_valid)
                    check("r_hold_pc", ifid_pc, prev_pc);
            end else if (ifid_valid) begin
                check("r_deliv_pc",    ifid_pc, exp_pc);
                check("r_deliv_instr", ifid_instr, mem_word(exp_pc));
                check("r_deliv_pc4",   ifid_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end

            acc        = imem_req && imem_ready;
            acc_addr   = imem_addr;
            prev_stall = stall;
            prev_redir = redirect;
            prev_valid = ifid_valid;
            prev_instr = ifid_instr;
            prev_pc    = ifid_pc;
            if (redirect)
                exp_pc = {redirect_pc[31:2], 2'b00};

            @(posedge clk); #1;
        end

        check("r_liveness", {31'b0, (deliveries >= 100)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
